// File: rtl/multicycle_control_if.sv
// Control and status bundle between the multi-cycle sequencer and the RV32I datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_control_if #(parameter int DATA_WIDTH = 32);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  zero;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  MemWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  PCWrite;
  logic                  RegWrite;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [3:0]            ALUControl;
  logic [1:0]            ResultSrc;
  logic [2:0]            ImmSrc;
  logic [2:0]            AddressingControl;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] instret;

  modport master (
    input  op, funct3, funct7, zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc,
           AddressingControl, illegal, instret
  );

  modport slave (
    output op, funct3, funct7, zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc,
           AddressingControl, illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the shared-ALU, unified-memory RV32I datapath,
// with a retired-instruction counter.
module multicycle_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master ctrl
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK, S_TRAP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] instret_q;

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] src_a_c, src_b_c, result_src_c;
  logic [3:0] alu_c, alu_base, alu_r;
  logic [2:0] imm_c, addr_ctl_c;
  logic       r_ok, i_ok, load_ok, store_ok, br_ok;

  assign load_ok  = ctrl.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign store_ok = ctrl.funct3 inside {3'b000, 3'b001, 3'b010};
  assign br_ok    = ctrl.funct3 inside {3'b000, 3'b001};
  assign r_ok     = (ctrl.funct7 == 7'b0000000) ||
                    ((ctrl.funct7 == 7'b0100000) &&
                     ((ctrl.funct3 == 3'b000) || (ctrl.funct3 == 3'b101)));
  // Only the shift-immediates constrain funct7; elsewhere those bits are immediate.
  assign i_ok = (ctrl.funct3 == 3'b001) ? (ctrl.funct7 == 7'b0000000) :
                (ctrl.funct3 == 3'b101) ? ((ctrl.funct7 == 7'b0000000) ||
                                           (ctrl.funct7 == 7'b0100000)) : 1'b1;

  always_comb begin
    case (ctrl.funct3)
      3'b000:  alu_base = ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = ctrl.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end

  assign alu_r = ((ctrl.funct3 == 3'b000) && ctrl.funct7[5]) ? ALU_SUB : alu_base;

  always_comb begin
    case (ctrl.op)
      OP_LOAD, OP_OPI, OP_JALR: imm_c = 3'b000;
      OP_STORE:                 imm_c = 3'b001;
      OP_BR:                    imm_c = 3'b010;
      OP_JAL:                   imm_c = 3'b011;
      default:                  imm_c = 3'b000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    src_a_c      = 2'b00;
    src_b_c      = 2'b00;
    result_src_c = 2'b00;
    alu_c        = ALU_ADD;
    addr_ctl_c   = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        src_b_c      = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = ctrl.mem_ready;
        pc_write_c   = ctrl.mem_ready;
        if (ctrl.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a_c = 2'b01;
        src_b_c = 2'b01;
        case (ctrl.op)
          OP_R:     state_d = S_EXECR;
          OP_OPI:   state_d = S_EXECI;
          OP_LOAD:  state_d = load_ok  ? S_MEMADR : S_TRAP;
          OP_STORE: state_d = store_ok ? S_MEMADR : S_TRAP;
          OP_BR:    state_d = br_ok    ? S_BRANCH : S_TRAP;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a_c = 2'b10;
        src_b_c = 2'b01;
        state_d = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c  = 1'b1;
        adr_src_c  = 1'b1;
        addr_ctl_c = ctrl.funct3;
        if (ctrl.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        addr_ctl_c  = ctrl.funct3;
        if (ctrl.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a_c = 2'b10;
        src_b_c = 2'b00;
        if (r_ok) begin
          alu_c   = alu_r;
          state_d = S_ALUWB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXECI: begin
        src_a_c = 2'b10;
        src_b_c = 2'b01;
        if (i_ok) begin
          alu_c   = alu_base;
          state_d = S_ALUWB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = 2'b10;
        src_b_c    = 2'b00;
        alu_c      = ALU_SUB;
        pc_write_c = ctrl.funct3[0] ? ~ctrl.zero : ctrl.zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        src_a_c    = 2'b01;
        src_b_c    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        src_a_c      = 2'b10;
        src_b_c      = 2'b01;
        result_src_c = 2'b10;
        pc_write_c   = 1'b1;
        state_d      = S_JALRLINK;
      end
      S_JALRLINK: begin
        src_a_c = 2'b01;
        src_b_c = 2'b10;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == S_FETCH) && (state_q != S_FETCH)) instret_q <= instret_q + DATA_WIDTH'(1);
    end
  end

  // Reset leaves state in FETCH, which would otherwise assert mem_req; gate requests/enables.
  assign ctrl.mem_req           = mem_req_c   & rst;
  assign ctrl.MemWrite          = mem_write_c & rst;
  assign ctrl.IRWrite           = ir_write_c  & rst;
  assign ctrl.PCWrite           = pc_write_c  & rst;
  assign ctrl.RegWrite          = reg_write_c & rst;
  assign ctrl.AdrSrc            = adr_src_c;
  assign ctrl.ALUSrcA           = src_a_c;
  assign ctrl.ALUSrcB           = src_b_c;
  assign ctrl.ALUControl        = alu_c;
  assign ctrl.ResultSrc         = result_src_c;
  assign ctrl.ImmSrc            = imm_c;
  assign ctrl.AddressingControl = addr_ctl_c;
  assign ctrl.illegal           = (state_q == S_TRAP);
  assign ctrl.instret           = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle control pattern and compared cycle by cycle against the DUT.
module tb_multicycle_control;
  localparam int DW = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       mr;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b;
    logic [3:0] alu;
    logic [1:0] res;
    logic [2:0] imm, ac;
    logic       ill;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.DATA_WIDTH(DW)) bus ();
  multicycle_control #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .ctrl(bus));

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt = 0;
  cyc_t exp_q[$];

  function automatic cyc_t base(input logic [6:0] op, input logic mr);
    cyc_t c = '0;
    c.mr  = mr;
    c.alu = 4'b0000;
    if (op == OP_LOAD || op == OP_OPI || op == OP_JALR) c.imm = 3'b000;
    else if (op == OP_STORE) c.imm = 3'b001;
    else if (op == OP_BR)    c.imm = 3'b010;
    else if (op == OP_JAL)   c.imm = 3'b011;
    return c;
  endfunction

  function automatic logic [3:0] alu_exp(input bit rtype, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    return (rtype && f7 == 7'h20) ? 4'b0001 : 4'b0000;
      3'd1:    return 4'b0111;
      3'd2:    return 4'b0101;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0100;
      3'd5:    return (f7 == 7'h20) ? 4'b1011 : 4'b1000;
      3'd6:    return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  // 0 = legal, 1 = rejected at decode, 2 = rejected at execute
  function automatic int trap_point(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      OP_R:     return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? 0 : 2;
      OP_OPI: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? 0 : 2;
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? 0 : 2;
        return 0;
      end
      OP_LOAD:  return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) ? 0 : 1;
      OP_STORE: return (f3 <= 3'd2) ? 0 : 1;
      OP_BR:    return (f3 <= 3'd1) ? 0 : 1;
      OP_JAL, OP_JALR: return 0;
      default:  return 1;
    endcase
  endfunction

  function automatic cyc_t sample(input logic mr);
    cyc_t a;
    a.mr = mr;
    a.mem_req = bus.mem_req;   a.mem_write = bus.MemWrite; a.adr_src = bus.AdrSrc;
    a.ir_write = bus.IRWrite;  a.pc_write = bus.PCWrite;   a.reg_write = bus.RegWrite;
    a.src_a = bus.ALUSrcA;     a.src_b = bus.ALUSrcB;      a.alu = bus.ALUControl;
    a.res = bus.ResultSrc;     a.imm = bus.ImmSrc;         a.ac = bus.AddressingControl;
    a.ill = bus.illegal;
    return a;
  endfunction

  task automatic push_trap(input logic [6:0] op);
    cyc_t c;
    for (int i = 0; i < 10; i++) begin
      c = base(op, 1'($urandom));
      c.ill = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  task automatic push_aluwb(input logic [6:0] op);
    cyc_t c = base(op, 1'($urandom));
    c.reg_write = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input int fw, input int mw, output bit retire);
    cyc_t c;
    int tp = trap_point(op, f3, f7);
    retire = 0;
    for (int i = 0; i <= fw; i++) begin
      c = base(op, i == fw);
      c.mem_req = 1'b1; c.src_b = 2'b10; c.res = 2'b10;
      c.ir_write = (i == fw); c.pc_write = (i == fw);
      exp_q.push_back(c);
    end
    c = base(op, 1'($urandom)); c.src_a = 2'b01; c.src_b = 2'b01;
    exp_q.push_back(c);
    if (tp == 1) begin push_trap(op); return; end
    c = base(op, 1'($urandom));
    case (op)
      OP_R, OP_OPI: begin
        c.src_a = 2'b10; c.src_b = (op == OP_R) ? 2'b00 : 2'b01;
        if (tp == 0) c.alu = alu_exp(op == OP_R, f3, f7);
        exp_q.push_back(c);
        if (tp == 2) begin push_trap(op); return; end
        push_aluwb(op);
      end
      OP_LOAD, OP_STORE: begin
        c.src_a = 2'b10; c.src_b = 2'b01;
        exp_q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
          c = base(op, i == mw);
          c.mem_req = 1'b1; c.adr_src = 1'b1; c.ac = f3; c.mem_write = (op == OP_STORE);
          exp_q.push_back(c);
        end
        if (op == OP_LOAD) begin
          c = base(op, 1'($urandom)); c.res = 2'b01; c.reg_write = 1'b1;
          exp_q.push_back(c);
        end
      end
      OP_BR: begin
        c.src_a = 2'b10; c.alu = 4'b0001;
        c.pc_write = (f3 == 3'd0) ? z : ~z;
        exp_q.push_back(c);
      end
      OP_JAL: begin
        c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1;
        exp_q.push_back(c);
        push_aluwb(op);
      end
      default: begin
        c.src_a = 2'b10; c.src_b = 2'b01; c.res = 2'b10; c.pc_write = 1'b1;
        exp_q.push_back(c);
        c = base(op, 1'($urandom)); c.src_a = 2'b01; c.src_b = 2'b10;
        exp_q.push_back(c);
        push_aluwb(op);
      end
    endcase
    retire = 1;
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int fw, input int mw,
                           input int abort_at = -1);
    bit   retire;
    int   idx = 0;
    cyc_t e, a;
    exp_q.delete();
    build(op, f3, f7, z, fw, mw, retire);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (idx == 0) begin
        bus.op = op; bus.funct3 = f3; bus.funct7 = f7; bus.zero = z;
        vectors++;
        if (bus.instret !== DW'(exp_cnt)) begin
          miscompares++;
          $display("FAIL %s instret_before: got %0d want %0d", name, bus.instret, exp_cnt);
        end
      end
      bus.mem_ready = e.mr;
      #1;
      a = sample(e.mr);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h want %h", name, idx, a, e);
      end
      if (idx == abort_at) return;
      idx++;
    end
    if (retire) exp_cnt = (exp_cnt + 1) % (1 << DW);
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.illegal} !== 6'b0 ||
        bus.instret !== '0) begin
      miscompares++;
      $display("FAIL %s: got req/we/ir/pc/rw/ill=%b%b%b%b%b%b instret=%0d want all 0",
               name, bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite,
               bus.illegal, bus.instret);
    end
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs(name);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic rand_legal(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
    logic [6:0] ops[7];
    int sel;
    ops = '{OP_R, OP_OPI, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};
    for (int t = 0; t < 100; t++) begin
      op  = ops[$urandom_range(0, 6)];
      f3  = 3'($urandom);
      sel = $urandom_range(0, 2);
      f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
      if (trap_point(op, f3, f7) == 0) return;
    end
    op = OP_R; f3 = 3'd0; f7 = 7'h00;
  endtask

  task automatic test_reset();
    bus.op = OP_R; bus.funct3 = '0; bus.funct7 = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3 check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    bus.mem_ready = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_add();
    run_instr("add", OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("sub", OP_R, 3'b000, 7'h20, 1'b0, 0, 0);
    run_instr("srai", OP_OPI, 3'b101, 7'h20, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", OP_LOAD, 3'b010, 7'h00, 1'b0, 0, 2);
    run_instr("sw_wait", OP_STORE, 3'b001, 7'h00, 1'b0, 0, 1);
  endtask

  task automatic test_branch();
    run_instr("beq_z1", OP_BR, 3'b000, 7'h00, 1'b1, 0, 0);
    run_instr("bne_z1", OP_BR, 3'b001, 7'h00, 1'b1, 0, 0);
    run_instr("beq_z0", OP_BR, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("bne_z0", OP_BR, 3'b001, 7'h00, 1'b0, 0, 0);
  endtask

  task automatic test_jumps();
    run_instr("jalr", OP_JALR, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("jal", OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [6:0] op, f7;
    logic [2:0] f3;
    for (int i = 0; i < 40; i++) begin
      rand_legal(op, f3, f7);
      run_instr("random", op, f3, f7, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops[6];
    logic [2:0] f3s[6];
    logic [6:0] f7s[6];
    ops = '{7'b0001111, OP_BR, OP_R,   OP_OPI, OP_LOAD, OP_STORE};
    f3s = '{3'd0,       3'd2,  3'd0,   3'd1,   3'd3,    3'd4};
    f7s = '{7'h00,      7'h00, 7'h01,  7'h20,  7'h00,   7'h00};
    for (int i = 0; i < 6; i++) begin
      run_instr("retire_before_trap", OP_R, 3'd7, 7'h00, 1'b0, 0, 0);
      run_instr("illegal", ops[i], f3s[i], f7s[i], 1'b0, 1, 0);
      vectors++;
      if (bus.instret !== DW'(exp_cnt)) begin
        miscompares++;
        $display("FAIL illegal_instret case %0d: got %0d want %0d", i, bus.instret, exp_cnt);
      end
      apply_reset("reset_after_trap");
    end
  endtask

  task automatic test_reset_mid();
    run_instr("pre_add", OP_R, 3'b100, 7'h00, 1'b0, 0, 0);
    run_instr("pre_jal", OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0);
    run_instr("sw_abort", OP_STORE, 3'b010, 7'h00, 1'b0, 0, 6, 4);
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset_mid_memwrite");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    run_instr("post_reset_add", OP_R, 3'b000, 7'h00, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core. Replaces the single-cycle decoder when the datapath shares one ALU and one unified memory port across several cycles per instruction. Each cycle it drives the datapath's mux selects, enables, ALU operation and memory handshake from a Moore state machine. It also counts retired instructions.

## Interface
- DATA_WIDTH, 32, width of the retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; **one clock; reset is asynchronous and active-low**
- op  in  7  opcode from the instruction register
- funct3  in  3  funct3 from the instruction register
- funct7  in  7  funct7 from the instruction register
- zero  in  1  ALU zero flag (valid in BRANCH)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write request (only with mem_req)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- ALUControl  out  4  ALU operation: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1011
- ResultSrc  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J
- AddressingControl  out  3  load/store width; equals funct3 in MEMREAD and MEMWRITE, else 000
- illegal  out  1  sticky illegal-instruction flag
- instret  out  DATA_WIDTH  retired-instruction count

## Operation
**States and transitions:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRLINK, TRAP.

**Default output values:** every output not listed for a state below is 0, with these exceptions:
- ALUControl defaults to add.
- ImmSrc follows op in every state (I for 0000011/0010011/1100111, S for 0100011, B for 1100011, J for 1101111, else 000).

**Per-state behaviour:**
- FETCH
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01 (branch/JAL target latched into ALUOut).
  - Next state by op:
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 0000011 or 0100011 → MEMADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - anything else → TRAP
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD
  - Outputs: mem_req=1, AdrSrc=1.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1.
  - Goes to FETCH.
- MEMWRITE
  - Outputs: mem_req=1, MemWrite=1, AdrSrc=1.
  - Holds until mem_ready, then goes to FETCH.
- EXECR
  - Outputs: ALUSrcA=10, ALUSrcB=00; ALUControl from funct3/funct7.
  - funct7 must be 0000000, except 0100000 for sub/sra.
  - Goes to ALUWB.
- EXECI
  - Outputs: ALUSrcA=10, ALUSrcB=01; ALUControl from funct3.
  - funct3 101 uses funct7 to select srli/srai.
  - Goes to ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1.
  - Goes to FETCH.
- BRANCH
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=zero for funct3 000 (beq), PCWrite=~zero for funct3 001 (bne).
  - Goes to FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1.
  - Goes to ALUWB, which writes OldPC+4 to rd.
- JALR
  - Outputs: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1.
  - Goes to JALRLINK.
- JALRLINK
  - Outputs: ALUSrcA=01, ALUSrcB=10.
  - Goes to ALUWB.
- TRAP
  - All enables and mem_req are 0; illegal=1.
  - Absorbing until reset.

**Illegal encodings (all go to TRAP):**
- Unknown op.
- Branch funct3 not 000/001.
- Load funct3 not in {000,001,010,100,101}.
- Store funct3 not in {000,001,010}.
- R/I-shift funct7 not one of the legal values above.
- Detected in DECODE (op, branch/load/store funct3) or in EXECR/EXECI (funct3/funct7 combinations). When detected in EXECR/EXECI, the state goes to TRAP with RegWrite kept 0.

**Retired-instruction counter:**
- instret increments by 1 on every transition into FETCH from any other state.
- Wraps modulo 2^DATA_WIDTH.

## Timing
- Reset is asynchronous, active-low. While asserted and after release:
  - state = FETCH, instret = 0, illegal = 0.
  - mem_req, MemWrite, IRWrite, PCWrite and RegWrite are forced 0 while rst=0.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after release; the first post-reset cycle is FETCH.
- Outputs are combinational from state plus op, funct3, funct7, zero and mem_ready; mem_ready must be stable before the clock edge.
- Latency with mem_ready=1, counted in cycles including FETCH:
  - R-type, I-ALU, store, JAL: 4
  - load, JALR: 5
  - branch: 3
- Each cycle mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds exactly one cycle, with request outputs held constant.
- mem_req stays high until the completing cycle. mem_ready is ignored in states that do not drive mem_req.

## Test plan
- **add:** op=0110011, funct3=000, funct7=0, mem_ready=1 → states FETCH, DECODE, EXECR (ALUControl=0000), ALUWB (RegWrite=1); instret 0→1 on the 4th edge.
- **lw with memory wait:** op=0000011, funct3=010, mem_ready low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles with AdrSrc=1 and AddressingControl=010; then MEMWB with ResultSrc=01 and RegWrite=1; 7 cycles total.
- **beq/bne:** beq with zero=1 → PCWrite=1 in BRANCH; bne with zero=1 → PCWrite=0; both return to FETCH after 3 cycles.
- **jalr:** op=1100111 → JALR (PCWrite=1, ResultSrc=10), then JALRLINK, then ALUWB (RegWrite=1); 5 cycles.
- **Illegal instruction:** op=0001111 → TRAP after DECODE; illegal=1, all enables 0 for 10+ cycles; instret unchanged.
- **Reset mid-operation:** rst low during MEMWRITE with mem_ready=0 → MemWrite and mem_req drop asynchronously; state=FETCH, instret=0 and illegal=0 after release.
